// File: rtl/fphub_pkg.sv
// Shared types and constants for the FPHUB operand stage.
package fphub_pkg;

  localparam int unsigned IEEE_FRAC_W   = 23;
  localparam int unsigned IEEE_EXP_W    = 8;
  localparam int unsigned IEEE_W        = IEEE_EXP_W + IEEE_FRAC_W + 1;
  localparam int unsigned IEEE_SIGN_POS = IEEE_W - 1;
  localparam int unsigned IEEE_EXP_LSB  = IEEE_FRAC_W;

  localparam int unsigned HUB_FRAC_W = 24;
  localparam logic [HUB_FRAC_W-1:0] HUB_NAN_FRAC = 24'h800000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } opst_state_e;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } hub_flags_t;

endpackage

// File: rtl/ieee_to_fphub_conv.sv
// Combinational IEEE-754 to HUB conversion with special-value classification.
module ieee_to_fphub_conv
  import fphub_pkg::*;
#(
  parameter int unsigned M    = 24,
  parameter int unsigned E    = 8,
  parameter int unsigned IN_M = 23,
  parameter int unsigned IN_E = 8
) (
  input  logic [IN_E+IN_M:0] ieee,
  output logic [E+M:0]       hub,
  output hub_flags_t         flags
);

  localparam logic [M-1:0] NAN_FRAC = {1'b1, {(M-1){1'b0}}};

  logic            sgn;
  logic [IN_E-1:0] exp_f;
  logic [IN_M-1:0] frac_f;
  logic            exp_ones;
  logic            exp_zero;
  logic            frac_zero;

  assign sgn       = ieee[IN_E+IN_M];
  assign exp_f     = ieee[IN_E+IN_M-1:IN_M];
  assign frac_f    = ieee[IN_M-1:0];
  assign exp_ones  = &exp_f;
  assign exp_zero  = ~|exp_f;
  assign frac_zero = ~|frac_f;

  // Truncating append of zero LSBs is already the nearest HUB value.
  always_comb begin
    flags = '0;
    hub   = {sgn, E'(exp_f), M'(M'(frac_f) << (M - IN_M))};
    if (exp_ones && !frac_zero) begin
      flags.nan = 1'b1;
      hub       = {1'b0, {E{1'b1}}, NAN_FRAC};
    end else if (exp_ones) begin
      flags.inf = 1'b1;
      hub       = {sgn, {E{1'b1}}, {M{1'b0}}};
    end else if (exp_zero) begin
      flags.zero = 1'b1;
      hub        = {sgn, {(E+M){1'b0}}};
    end
  end

endmodule

// File: rtl/fphub_operand_stage.sv
// Operand input stage: converts IEEE pairs to HUB and buffers them in a
// 2-entry skid buffer (output register + skid register) toward the adder.
module fphub_operand_stage
  import fphub_pkg::*;
#(
  parameter int unsigned M     = 24,
  parameter int unsigned E     = 8,
  parameter int unsigned IN_M  = 23,
  parameter int unsigned IN_E  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_E+IN_M:0] in_a,
  input  logic [IN_E+IN_M:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [E+M:0]       X,
  output logic [E+M:0]       Y,
  output logic [5:0]         flags,
  output logic [CNT_W-1:0]   pair_count
);

  opst_state_e state, state_nxt;

  logic [E+M:0]     conv_x, conv_y;
  hub_flags_t       conv_fa, conv_fb;
  logic [E+M:0]     sk_x, sk_y;
  logic [5:0]       sk_flags;
  logic [E+M:0]     x_nxt, y_nxt, sk_x_nxt, sk_y_nxt;
  logic [5:0]       flags_nxt, sk_flags_nxt;
  logic [CNT_W-1:0] pair_count_nxt;
  logic             in_ready_nxt, out_valid_nxt;
  logic             acc, dlv;

  ieee_to_fphub_conv #(.M(M), .E(E), .IN_M(IN_M), .IN_E(IN_E)) u_conv_a (
    .ieee  (in_a),
    .hub   (conv_x),
    .flags (conv_fa)
  );

  ieee_to_fphub_conv #(.M(M), .E(E), .IN_M(IN_M), .IN_E(IN_E)) u_conv_b (
    .ieee  (in_b),
    .hub   (conv_y),
    .flags (conv_fb)
  );

  assign acc = in_valid && in_ready;
  assign dlv = out_valid && out_ready;

  // Next state and datapath; in_ready/out_valid are registered state decodes.
  always_comb begin
    state_nxt      = state;
    x_nxt          = X;
    y_nxt          = Y;
    flags_nxt      = flags;
    sk_x_nxt       = sk_x;
    sk_y_nxt       = sk_y;
    sk_flags_nxt   = sk_flags;
    pair_count_nxt = pair_count + CNT_W'(acc);
    case (state)
      EMPTY: begin
        if (acc) begin
          x_nxt     = conv_x;
          y_nxt     = conv_y;
          flags_nxt = {conv_fa, conv_fb};
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (acc && !dlv) begin
          sk_x_nxt     = conv_x;
          sk_y_nxt     = conv_y;
          sk_flags_nxt = {conv_fa, conv_fb};
          state_nxt    = FULL;
        end else if (acc && dlv) begin
          x_nxt     = conv_x;
          y_nxt     = conv_y;
          flags_nxt = {conv_fa, conv_fb};
        end else if (dlv) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (dlv) begin
          x_nxt     = sk_x;
          y_nxt     = sk_y;
          flags_nxt = sk_flags;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    in_ready_nxt  = (state_nxt != FULL);
    out_valid_nxt = (state_nxt != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      X          <= '0;
      Y          <= '0;
      flags      <= '0;
      sk_x       <= '0;
      sk_y       <= '0;
      sk_flags   <= '0;
      pair_count <= '0;
    end else begin
      state      <= state_nxt;
      in_ready   <= in_ready_nxt;
      out_valid  <= out_valid_nxt;
      X          <= x_nxt;
      Y          <= y_nxt;
      flags      <= flags_nxt;
      sk_x       <= sk_x_nxt;
      sk_y       <= sk_y_nxt;
      sk_flags   <= sk_flags_nxt;
      pair_count <= pair_count_nxt;
    end
  end

endmodule
